// File: rtl/c432_key_pkg.sv
// Shared constants and types for the c432 key loader.
// Optional trailing even-parity bit is enabled by defining KEY_PARITY_EN.
package c432_key_pkg;

    localparam int unsigned MUX_W     = 4;
    localparam int unsigned XOR_W     = 9;
    localparam int unsigned KEY_W     = MUX_W + XOR_W;
    localparam int unsigned RETRY_MAX = 3;

`ifdef KEY_PARITY_EN
    localparam int unsigned NBITS = KEY_W + 1;
`else
    localparam int unsigned NBITS = KEY_W;
`endif

    localparam int unsigned CNT_W   = $clog2(KEY_W + 2);
    localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, LOCKED, ERROR} key_state_t;

    typedef struct packed {
        logic [XOR_W-1:0] x;
        logic [MUX_W-1:0] p;
    } c432_key_t;

endpackage

// File: rtl/c432_key_shreg.sv
// Shadow key register and bit counter; flags the final accepted bit.
// With KEY_PARITY_EN the running parity of all received bits drives check_ok_o.
module c432_key_shreg
    import c432_key_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr_i,
    input  logic      bit_en_i,
    input  logic      bit_i,
    output c432_key_t shadow_o,
    output logic      done_o,
    output logic      check_ok_o
);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            shadow_d = '0;
            cnt_d    = '0;
        end else if (bit_en_i) begin
            // The parity bit, when present, only feeds the parity accumulator.
            if (cnt_q < CNT_W'(KEY_W)) shadow_d[cnt_q] = bit_i;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign shadow_o = c432_key_t'(shadow_q);
    assign done_o   = bit_en_i && (cnt_q == CNT_W'(NBITS - 1));

`ifdef KEY_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (clr_i)         par_d = 1'b0;
        else if (bit_en_i) par_d = par_q ^ bit_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign check_ok_o = ~par_q;
`else
    assign check_ok_o = 1'b1;
`endif

endmodule

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 core: shift, check, commit, with retry lockout.
// Parity checking is enabled by defining KEY_PARITY_EN.
module c432_key_loader
    import c432_key_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_req_i,
    input  logic             zeroize_i,
    input  logic             kin_valid_i,
    input  logic             kin_bit_i,
    output logic             kin_ready_o,
    output logic [MUX_W-1:0] key_mux_o,
    output logic [XOR_W-1:0] key_xor_o,
    output logic             key_valid_o,
    output logic             key_err_o,
    output logic             busy_o
);

    key_state_t         state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    c432_key_t          key_q, key_d, shadow;
    logic               key_valid_q, key_valid_d;
    logic               key_err_q, key_err_d;
    logic               kin_ready_q, kin_ready_d;
    logic               busy_q, busy_d;
    logic               start, bit_en, done, check_ok, lockout;

    assign bit_en  = kin_valid_i & kin_ready_q;
    assign lockout = (retry_q >= RETRY_W'(RETRY_MAX));

    c432_key_shreg u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (start | zeroize_i),
        .bit_en_i   (bit_en),
        .bit_i      (kin_bit_i),
        .shadow_o   (shadow),
        .done_o     (done),
        .check_ok_o (check_ok)
    );

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        key_err_d   = key_err_q;
        start       = 1'b0;
        unique case (state_q)
            IDLE, ERROR: begin
                if (load_req_i && !lockout) begin
                    state_d   = SHIFT;
                    start     = 1'b1;
                    key_err_d = 1'b0;
                end
            end
            SHIFT: if (done) state_d = CHECK;
            CHECK: begin
                if (check_ok) begin
                    state_d = LOCKED;
                end else begin
                    state_d   = ERROR;
                    key_err_d = 1'b1;
                    if (!lockout) retry_d = retry_q + 1'b1;
                end
            end
            LOCKED: begin
                key_d       = shadow;
                key_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Zeroize overrides everything but keeps the retry count and key_err.
        if (zeroize_i) begin
            state_d     = IDLE;
            start       = 1'b0;
            key_d       = '0;
            key_valid_d = 1'b0;
        end
        kin_ready_d = (state_d == SHIFT);
        busy_d      = (state_d == SHIFT) || (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            retry_q     <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            kin_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            kin_ready_q <= kin_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign kin_ready_o = kin_ready_q;
    assign key_mux_o   = key_q.p;
    assign key_xor_o   = key_q.x;
    assign key_valid_o = key_valid_q;
    assign key_err_o   = key_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed bench for c432_key_loader with a transaction-level reference model.
// Define KEY_PARITY_EN to exercise the parity variant.
module tb_c432_key_loader;

    localparam int KW   = 13;
`ifdef KEY_PARITY_EN
    localparam int NB   = 14;
`else
    localparam int NB   = 13;
`endif
    localparam int RMAX = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_req = 1'b0, zeroize = 1'b0, kin_valid = 1'b0, kin_bit = 1'b0;
    logic       kin_ready, key_valid, key_err, busy;
    logic [3:0] key_mux;
    logic [8:0] key_xor;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    c432_key_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_req_i  (load_req),
        .zeroize_i   (zeroize),
        .kin_valid_i (kin_valid),
        .kin_bit_i   (kin_bit),
        .kin_ready_o (kin_ready),
        .key_mux_o   (key_mux),
        .key_xor_o   (key_xor),
        .key_valid_o (key_valid),
        .key_err_o   (key_err),
        .busy_o      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a received-bit list, a pending verdict, and a committed key.
    logic [NB-1:0] m_bits = '0;
    int            m_n = 0;
    logic          m_loading = 1'b0, m_verdict = 1'b0, m_pass = 1'b0, m_valid = 1'b0;
    logic          m_err = 1'b0;
    int            m_fails = 0;

    function automatic logic parity_ok(input logic [NB-1:0] b);
`ifdef KEY_PARITY_EN
        return (^b) == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bits <= '0; m_n <= 0; m_loading <= 1'b0; m_verdict <= 1'b0;
            m_pass <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0; m_fails <= 0;
        end else if (zeroize) begin
            m_bits <= '0; m_n <= 0; m_loading <= 1'b0; m_verdict <= 1'b0;
            m_pass <= 1'b0; m_valid <= 1'b0;
        end else begin
            if (m_verdict) begin
                m_verdict <= 1'b0;
                if (parity_ok(m_bits)) m_pass <= 1'b1;
                else begin
                    m_err   <= 1'b1;
                    m_fails <= m_fails + 1;
                end
            end else if (m_pass && !m_valid) begin
                m_valid <= 1'b1;
            end
            if (m_loading && kin_valid) begin
                m_bits[m_n] <= kin_bit;
                m_n <= m_n + 1;
                if (m_n + 1 == NB) begin
                    m_loading <= 1'b0;
                    m_verdict <= 1'b1;
                end
            end else if (load_req && !m_loading && !m_verdict && !m_pass && m_fails < RMAX) begin
                m_loading <= 1'b1;
                m_n       <= 0;
                m_bits    <= '0;
                m_err     <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_ready", kin_ready, m_loading);
            check("m_busy", busy, m_loading | m_verdict);
            check("m_valid", key_valid, m_valid);
            check("m_err", key_err, m_err);
            check("m_mux", key_mux, m_valid ? m_bits[3:0] : 4'h0);
            check("m_xor", key_xor, m_valid ? m_bits[KW-1:4] : 9'h0);
        end
    end

    task automatic pulse_load();
        @(negedge clk) load_req = 1'b1;
        @(posedge clk) #1 load_req = 1'b0;
    endtask

    task automatic pulse_zeroize();
        @(negedge clk) zeroize = 1'b1;
        @(posedge clk) #1 zeroize = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        @(negedge clk);
        while (!kin_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", kin_ready, 1);
        kin_valid = 1'b1;
        kin_bit   = b;
        @(posedge clk) #1 kin_valid = 1'b0;
    endtask

    task automatic send_key(input logic [KW-1:0] k, input logic par, input int gap);
        for (int i = 0; i < NB; i++) begin
            send_bit((i < KW) ? k[i] : par);
            if (i != NB - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_ready", kin_ready, 1);
                end
            end
        end
    endtask

    // Called right after the edge that accepted the final bit of a good key.
    task automatic expect_commit(input logic [3:0] mux, input logic [8:0] xr);
        @(negedge clk);
        check("e1_valid", key_valid, 0);
        check("e1_busy", busy, 1);
        @(negedge clk);
        check("e2_valid", key_valid, 0);
        @(negedge clk);
        check("e3_valid", key_valid, 1);
        check("e3_mux", key_mux, mux);
        check("e3_xor", key_xor, xr);
        check("e3_err", key_err, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", kin_ready, 0);
        check("rst_valid", key_valid, 0);
        check("rst_mux", key_mux, 0);
        check("rst_xor", key_xor, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", kin_ready, 0);
        check("idle_busy", busy, 0);

        // Good load, back-to-back bits
        pulse_load();
        @(negedge clk);
        check("start_ready", kin_ready, 1);
        send_key(13'h0F0F, 1'b0, 0);
        expect_commit(4'hF, 9'h0F0);

        // Load ignored while locked
        pulse_load();
        @(negedge clk);
        check("locked_ignore", kin_ready, 0);
        check("locked_hold", key_mux, 4'hF);

        // Same key with gaps
        pulse_zeroize();
        pulse_load();
        send_key(13'h0F0F, 1'b0, 3);
        expect_commit(4'hF, 9'h0F0);

        // Zeroize wins over load_req
        @(negedge clk) begin zeroize = 1'b1; load_req = 1'b1; end
        @(posedge clk) #1 begin zeroize = 1'b0; load_req = 1'b0; end
        @(negedge clk);
        check("z_valid", key_valid, 0);
        check("z_mux", key_mux, 0);
        check("z_xor", key_xor, 0);
        check("z_busy", busy, 0);
        check("z_ready", kin_ready, 0);
        pulse_load();
        @(negedge clk);
        check("z_restart", kin_ready, 1);

        // Reset after 7 bits, then reload a different key
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", kin_ready, 0);
        check("mid_rst_mux", key_mux, 0);
        rst_n = 1'b1;
        pulse_load();
        send_key(13'h1555, 1'b1, 0);
        expect_commit(4'h5, 9'h155);

`ifdef KEY_PARITY_EN
        // Parity failures up to lockout
        pulse_zeroize();
        for (int r = 0; r < RMAX; r++) begin
            pulse_load();
            send_key(13'h0F0F, 1'b1, 0);
            @(negedge clk);
            @(negedge clk);
            check("perr_err", key_err, 1);
            check("perr_valid", key_valid, 0);
            check("perr_mux", key_mux, 0);
        end
        pulse_load();
        repeat (3) begin
            @(negedge clk);
            check("lockout_ready", kin_ready, 0);
        end
        pulse_zeroize();
        pulse_load();
        @(negedge clk);
        check("lockout_sticky", kin_ready, 0);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        pulse_load();
        @(negedge clk);
        check("unlock_after_rst", kin_ready, 1);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
